dac_spi_tx: RTL and testbench

Downstream stage of the sawtooth generator. Captures the 16-bit oscillator sample at a fixed sample rate and serialises it to an external SPI DAC as a 24-bit frame (8-bit command byte + 16-bit code), MSB first. It provides a free-running sample-rate strobe, a busy/done status and sticky overrun detection.

---
 rtl/dac_spi_tx.sv | 160 ++++++++++++++++
 tb/tb_dac_spi_tx.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx.sv
// SPI transmitter for an external DAC: captures SAMPLE at a fixed sample rate and shifts out
// {DAC_CMD, SAMPLE} as a 24-bit MSB-first frame with busy/done status and sticky overrun.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_DIV = 2048,
    parameter logic [7:0]  DAC_CMD    = 8'h30
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOCKED,
    input  logic [15:0] SAMPLE,
    output logic        DAC_CS_N,
    output logic        DAC_SCLK,
    output logic        DAC_SDI,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic        OVERRUN
);

    localparam int unsigned       ScntW   = $clog2(SAMPLE_DIV);
    localparam logic [ScntW-1:0]  ScntMax = ScntW'(SAMPLE_DIV - 1);
    localparam logic [7:0]        HalfMax = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    state_t             state_q, state_d;
    logic [ScntW-1:0]   scnt_q, scnt_d;
    logic [7:0]         hcnt_q, hcnt_d;
    logic [4:0]         bcnt_q, bcnt_d;
    logic [23:0]        shreg_q, shreg_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               sdi_q, sdi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               tick;
    logic               half_last;

    assign tick      = LOCKED && (scnt_q == ScntMax);
    assign half_last = (hcnt_q == HalfMax);

    always_comb begin
        if (!LOCKED || scnt_q == ScntMax) begin
            scnt_d = '0;
        end else begin
            scnt_d = scnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q + 8'd1;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        sdi_d   = sdi_q;
        done_d  = 1'b0;
        // A tick arriving in any non-idle state (including the last GAP cycle) is dropped.
        ovr_d   = ovr_q | (tick && state_q != StIdle);

        case (state_q)
            StIdle: begin
                hcnt_d = 8'd0;
                if (tick) begin
                    shreg_d = {DAC_CMD, SAMPLE};
                    sdi_d   = DAC_CMD[7];
                    cs_n_d  = 1'b0;
                    bcnt_d  = 5'd0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (half_last) begin
                    hcnt_d  = 8'd0;
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (half_last) begin
                    hcnt_d = 8'd0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: advance to the next bit.
                        shreg_d = {shreg_q[22:0], 1'b0};
                        sdi_d   = shreg_q[22];
                        if (bcnt_q == 5'd23) begin
                            state_d = StHold;
                        end else begin
                            bcnt_d = bcnt_q + 5'd1;
                        end
                    end
                end
            end
            StHold: begin
                if (half_last) begin
                    hcnt_d  = 8'd0;
                    cs_n_d  = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (half_last) begin
                    hcnt_d  = 8'd0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            scnt_q  <= '0;
            hcnt_q  <= 8'd0;
            bcnt_q  <= 5'd0;
            shreg_q <= 24'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign DAC_CS_N   = cs_n_q;
    assign DAC_SCLK   = sclk_q;
    assign DAC_SDI    = sdi_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three parameterisations share inputs; a monitor decodes SPI frames
// from the selected instance and each test compares them against a tick/frame model.
module tb_dac_spi_tx;

    logic        CLK;
    logic        RST_N;
    logic        LOCKED;
    logic [15:0] SAMPLE;
    logic [2:0]  cs_n_w, sclk_w, sdi_w, busy_w, done_w, ovr_w;
    logic [1:0]  sel;
    logic        cs_n, sclk, sdi, busy, done, ovr;
    int          div;
    int          n_assert = 0;
    int          n_fail   = 0;

    dac_spi_tx #(.CLK_DIV(4), .SAMPLE_DIV(2048), .DAC_CMD(8'h30)) u_dut_def (
        .CLK(CLK), .RST_N(RST_N), .LOCKED(LOCKED), .SAMPLE(SAMPLE),
        .DAC_CS_N(cs_n_w[0]), .DAC_SCLK(sclk_w[0]), .DAC_SDI(sdi_w[0]),
        .BUSY(busy_w[0]), .FRAME_DONE(done_w[0]), .OVERRUN(ovr_w[0])
    );
    dac_spi_tx #(.CLK_DIV(4), .SAMPLE_DIV(150), .DAC_CMD(8'h30)) u_dut_ovr (
        .CLK(CLK), .RST_N(RST_N), .LOCKED(LOCKED), .SAMPLE(SAMPLE),
        .DAC_CS_N(cs_n_w[1]), .DAC_SCLK(sclk_w[1]), .DAC_SDI(sdi_w[1]),
        .BUSY(busy_w[1]), .FRAME_DONE(done_w[1]), .OVERRUN(ovr_w[1])
    );
    dac_spi_tx #(.CLK_DIV(1), .SAMPLE_DIV(51), .DAC_CMD(8'h30)) u_dut_fast (
        .CLK(CLK), .RST_N(RST_N), .LOCKED(LOCKED), .SAMPLE(SAMPLE),
        .DAC_CS_N(cs_n_w[2]), .DAC_SCLK(sclk_w[2]), .DAC_SDI(sdi_w[2]),
        .BUSY(busy_w[2]), .FRAME_DONE(done_w[2]), .OVERRUN(ovr_w[2])
    );

    assign cs_n = cs_n_w[sel];
    assign sclk = sclk_w[sel];
    assign sdi  = sdi_w[sel];
    assign busy = busy_w[sel];
    assign done = done_w[sel];
    assign ovr  = ovr_w[sel];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Edge counter and the SAMPLE value seen at each edge.
    int          cyc = 0;
    logic [15:0] hist [0:65535];

    initial forever begin
        @(posedge CLK);
        cyc++;
        hist[cyc % 65536] = SAMPLE;
    end

    function automatic logic [15:0] samp_at(input int c);
        return hist[c % 65536];
    endfunction

    typedef struct {
        int          start;
        int          stop;
        logic [23:0] word;
        int          bits;
        bit          first_ok;
        bit          gap_ok;
        bit          busy_ok;
    } frame_t;

    frame_t fq[$];
    int     dq[$];
    frame_t cur;
    bit     in_frame = 0;
    int     last_rise;
    logic   prev_cs   = 1'b1;
    logic   prev_sclk = 1'b0;

    // SPI receiver: samples SDI on each SCLK rise, records frame timing.
    initial forever begin
        @(negedge CLK);
        if (prev_cs === 1'b1 && cs_n === 1'b0) begin
            in_frame     = 1;
            cur.start    = cyc;
            cur.stop     = 0;
            cur.word     = 24'd0;
            cur.bits     = 0;
            cur.first_ok = 1;
            cur.gap_ok   = 1;
            cur.busy_ok  = (busy === 1'b1);
            last_rise    = 0;
        end
        if (in_frame && prev_sclk === 1'b0 && sclk === 1'b1) begin
            if (cur.bits == 0) begin
                if (cyc != cur.start + div) cur.first_ok = 0;
            end else if (cyc - last_rise != 2 * div) begin
                cur.gap_ok = 0;
            end
            last_rise = cyc;
            cur.word  = {cur.word[22:0], sdi};
            cur.bits++;
        end
        if (in_frame && prev_cs === 1'b0 && cs_n === 1'b1) begin
            cur.stop = cyc;
            fq.push_back(cur);
            in_frame = 0;
        end
        if (done === 1'b1) dq.push_back(cyc);
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    // Tick/frame model: ticks every sdiv edges after lock; a tick starts a frame only if the
    // previous frame (50*d cycles) has fully finished. Returns the first dropped tick or -1.
    int exp_q[$];

    function automatic int model_starts(input int l, input int d, input int s, input int hz);
        int first_drop = -1;
        int busy_until = -1;
        exp_q.delete();
        for (int t = l + s - 1; t <= hz; t += s) begin
            if (t > busy_until) begin
                exp_q.push_back(t);
                busy_until = t + 50 * d;
            end else if (first_drop < 0) begin
                first_drop = t;
            end
        end
        return first_drop;
    endfunction

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic select_dut(input int s);
        sel = 2'(s);
        div = (s == 2) ? 1 : 4;
    endtask

    task automatic clear_log();
        fq.delete();
        dq.delete();
        in_frame = 0;
    endtask

    task automatic do_reset();
        step();
        RST_N  = 1'b0;
        LOCKED = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        clear_log();
    endtask

    task automatic raise_lock(output int l);
        step();
        LOCKED = 1'b1;
        l = cyc + 1;
    endtask

    task automatic wait_bits(input int k, input int budget, output bit found);
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (in_frame && cur.bits == k) found = 1;
        end
    endtask

    int lock_l;

    task automatic test_reset();
        RST_N  = 1'b1;
        LOCKED = 1'b0;
        SAMPLE = 16'h0000;
        select_dut(0);
        #1 RST_N = 1'b0;
        repeat (2) step();
        for (int s = 0; s < 3; s++) begin
            n_assert += 6;
            if (cs_n_w[s] !== 1'b1) begin
                n_fail++; $display("FAIL reset_cs_n[%0d]: got %b want 1", s, cs_n_w[s]);
            end
            if (sclk_w[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_sclk[%0d]: got %b want 0", s, sclk_w[s]);
            end
            if (sdi_w[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_sdi[%0d]: got %b want 0", s, sdi_w[s]);
            end
            if (busy_w[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_w[s]);
            end
            if (done_w[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", s, done_w[s]);
            end
            if (ovr_w[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_ovr[%0d]: got %b want 0", s, ovr_w[s]);
            end
        end
        RST_N = 1'b1;
        clear_log();
    endtask

    task automatic test_first_frame();
        int drop;
        select_dut(0);
        do_reset();
        SAMPLE = 16'h8000;
        raise_lock(lock_l);
        drop = model_starts(lock_l, 4, 2048, lock_l + 2047);
        wait_until(exp_q[0] + 202);
        n_assert++;
        if (fq.size() != 1) begin
            n_fail++; $display("FAIL first_count: got %0d frames want 1", fq.size());
        end
        if (fq.size() >= 1) begin
            n_assert += 7;
            if (fq[0].start != lock_l + 2047) begin
                n_fail++;
                $display("FAIL first_start: got %0d want %0d", fq[0].start, lock_l + 2047);
            end
            if (fq[0].word !== 24'h308000) begin
                n_fail++; $display("FAIL first_word: got %h want 308000", fq[0].word);
            end
            if (fq[0].bits != 24) begin
                n_fail++; $display("FAIL first_bits: got %0d want 24", fq[0].bits);
            end
            if (!fq[0].first_ok) begin
                n_fail++; $display("FAIL first_rise: got late/early want start+%0d", div);
            end
            if (!fq[0].gap_ok) begin
                n_fail++; $display("FAIL first_spacing: got irregular want %0d", 2 * div);
            end
            if (!fq[0].busy_ok) begin
                n_fail++; $display("FAIL first_busy: got 0 want 1 at CS_N fall");
            end
            if (fq[0].stop != fq[0].start + 196) begin
                n_fail++;
                $display("FAIL first_cs_rise: got %0d want %0d", fq[0].stop, fq[0].start + 196);
            end
        end
        n_assert++;
        if (dq.size() != 1 || dq[0] != exp_q[0] + 200) begin
            n_fail++;
            $display("FAIL first_done: got %0d pulses (first %0d) want 1 at %0d",
                     dq.size(), (dq.size() > 0) ? dq[0] : -1, exp_q[0] + 200);
        end
        n_assert++;
        if (ovr !== 1'b0 || drop != -1) begin
            n_fail++; $display("FAIL first_ovr: got %b want 0", ovr);
        end
    endtask

    task automatic test_ramp();
        int drop;
        clear_log();
        drop = model_starts(lock_l, 4, 2048, lock_l + 2047 + 4 * 2048);
        void'(exp_q.pop_front());
        while (cyc < exp_q[$] + 202) begin
            SAMPLE = 16'($urandom);
            step();
        end
        n_assert++;
        if (fq.size() != 4) begin
            n_fail++; $display("FAIL ramp_count: got %0d frames want 4", fq.size());
        end
        for (int i = 0; i < 4 && i < fq.size(); i++) begin
            n_assert += 3;
            if (fq[i].start != exp_q[i]) begin
                n_fail++;
                $display("FAIL ramp_start[%0d]: got %0d want %0d", i, fq[i].start, exp_q[i]);
            end
            if (fq[i].word !== {8'h30, samp_at(exp_q[i])}) begin
                n_fail++;
                $display("FAIL ramp_word[%0d]: got %h want %h", i, fq[i].word,
                         {8'h30, samp_at(exp_q[i])});
            end
            if (fq[i].bits != 24) begin
                n_fail++; $display("FAIL ramp_bits[%0d]: got %0d want 24", i, fq[i].bits);
            end
        end
        n_assert += 2;
        if (dq.size() != 4) begin
            n_fail++; $display("FAIL ramp_done: got %0d want 4", dq.size());
        end
        if (ovr !== 1'b0 || drop != -1) begin
            n_fail++; $display("FAIL ramp_ovr: got %b want 0", ovr);
        end
    endtask

    task automatic test_lock_drop();
        bit found;
        int start;
        int l;
        clear_log();
        wait_bits(5, 2600, found);
        n_assert++;
        if (!found) begin
            n_fail++; $display("FAIL lockdrop_wait: got no frame want bit 5 reached");
        end
        LOCKED = 1'b0;
        start  = cur.start;
        wait_until(start + 2500);
        n_assert++;
        if (fq.size() != 1) begin
            n_fail++; $display("FAIL lockdrop_count: got %0d frames want 1", fq.size());
        end
        if (fq.size() >= 1) begin
            n_assert += 2;
            if (fq[0].bits != 24) begin
                n_fail++; $display("FAIL lockdrop_bits: got %0d want 24", fq[0].bits);
            end
            if (fq[0].word !== {8'h30, samp_at(start)}) begin
                n_fail++;
                $display("FAIL lockdrop_word: got %h want %h", fq[0].word,
                         {8'h30, samp_at(start)});
            end
        end
        n_assert++;
        if (dq.size() != 1 || dq[0] != start + 200) begin
            n_fail++;
            $display("FAIL lockdrop_done: got %0d pulses want 1 at %0d", dq.size(), start + 200);
        end
        raise_lock(l);
        wait_until(l + 2047 + 202);
        n_assert++;
        if (fq.size() != 2 || fq[fq.size() - 1].start != l + 2047) begin
            n_fail++;
            $display("FAIL relock_start: got %0d frames (last %0d) want 2 (last %0d)",
                     fq.size(), (fq.size() > 0) ? fq[fq.size() - 1].start : -1, l + 2047);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int l;
        SAMPLE = 16'hFFFF;
        clear_log();
        wait_bits(10, 2600, found);
        n_assert++;
        if (!found) begin
            n_fail++; $display("FAIL rstmid_wait: got no frame want bit 10 reached");
        end
        RST_N = 1'b0;
        #1;
        n_assert += 4;
        if (cs_n !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_cs_n: got %b want 1", cs_n);
        end
        if (sclk !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_sclk: got %b want 0", sclk);
        end
        if (sdi !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_sdi: got %b want 0", sdi);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy);
        end
        LOCKED = 1'b0;
        repeat (2) step();
        RST_N = 1'b1;
        clear_log();
        SAMPLE = 16'($urandom);
        raise_lock(l);
        wait_until(l + 2047 + 202);
        n_assert++;
        if (fq.size() != 1) begin
            n_fail++; $display("FAIL rstmid_count: got %0d frames want 1", fq.size());
        end
        if (fq.size() >= 1) begin
            n_assert += 3;
            if (fq[0].start != l + 2047) begin
                n_fail++;
                $display("FAIL rstmid_start: got %0d want %0d", fq[0].start, l + 2047);
            end
            if (fq[0].bits != 24) begin
                n_fail++; $display("FAIL rstmid_bits: got %0d want 24", fq[0].bits);
            end
            if (fq[0].word !== {8'h30, samp_at(l + 2047)}) begin
                n_fail++;
                $display("FAIL rstmid_word: got %h want %h", fq[0].word,
                         {8'h30, samp_at(l + 2047)});
            end
        end
    endtask

    task automatic test_overrun();
        int l;
        int hz;
        int drop;
        int n_seen;
        select_dut(1);
        do_reset();
        raise_lock(l);
        hz   = l + 700;
        drop = model_starts(l, 4, 150, hz);
        while (cyc < hz + 202) begin
            SAMPLE = 16'($urandom);
            step();
            if (cyc == drop - 1) begin
                n_assert++;
                if (ovr !== 1'b0) begin
                    n_fail++; $display("FAIL ovr_before: got %b want 0", ovr);
                end
            end
            if (cyc == drop) begin
                n_assert++;
                if (ovr !== 1'b1) begin
                    n_fail++; $display("FAIL ovr_set: got %b want 1", ovr);
                end
            end
        end
        n_assert++;
        if (ovr !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr);
        end
        n_seen = 0;
        foreach (fq[i]) if (fq[i].start <= hz) n_seen++;
        n_assert++;
        if (n_seen != exp_q.size()) begin
            n_fail++; $display("FAIL ovr_count: got %0d frames want %0d", n_seen, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < fq.size(); i++) begin
            n_assert += 3;
            if (fq[i].start != exp_q[i]) begin
                n_fail++;
                $display("FAIL ovr_start[%0d]: got %0d want %0d", i, fq[i].start, exp_q[i]);
            end
            if (fq[i].word !== {8'h30, samp_at(exp_q[i])}) begin
                n_fail++;
                $display("FAIL ovr_word[%0d]: got %h want %h", i, fq[i].word,
                         {8'h30, samp_at(exp_q[i])});
            end
            if (fq[i].bits != 24 || !fq[i].gap_ok) begin
                n_fail++;
                $display("FAIL ovr_bits[%0d]: got %0d bits gap_ok=%0d want 24 bits gap_ok=1",
                         i, fq[i].bits, fq[i].gap_ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        int l;
        int hz;
        int drop;
        int n_seen;
        int n_done;
        select_dut(2);
        do_reset();
        SAMPLE = 16'hFFFF;
        raise_lock(l);
        hz   = l + 50 + 5 * 51;
        drop = model_starts(l, 1, 51, hz);
        wait_until(hz + 52);
        n_seen = 0;
        foreach (fq[i]) if (fq[i].start <= hz) n_seen++;
        n_assert++;
        if (n_seen != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d frames want %0d", n_seen, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < fq.size(); i++) begin
            n_assert += 3;
            if (fq[i].start != exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_start[%0d]: got %0d want %0d", i, fq[i].start, exp_q[i]);
            end
            if (fq[i].word !== 24'h30FFFF) begin
                n_fail++; $display("FAIL b2b_word[%0d]: got %h want 30ffff", i, fq[i].word);
            end
            if (fq[i].bits != 24 || !fq[i].gap_ok || !fq[i].first_ok) begin
                n_fail++;
                $display("FAIL b2b_sclk[%0d]: got %0d bits gap_ok=%0d first_ok=%0d want 24/1/1",
                         i, fq[i].bits, fq[i].gap_ok, fq[i].first_ok);
            end
        end
        n_done = 0;
        foreach (dq[i]) if (dq[i] <= hz + 50) n_done++;
        n_assert++;
        if (n_done != exp_q.size() || dq.size() == 0 || dq[0] != exp_q[0] + 50) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d pulses (first %0d) want %0d (first %0d)", n_done,
                     (dq.size() > 0) ? dq[0] : -1, exp_q.size(), exp_q[0] + 50);
        end
        n_assert++;
        if (ovr !== 1'b0 || drop != -1) begin
            n_fail++; $display("FAIL b2b_ovr: got %b want 0", ovr);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_ramp();
        test_lock_drop();
        test_reset_mid();
        test_overrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
